quadrature_speed_meter: RTL and testbench
=========================================

# quadrature_speed_meter

Encoder front end feeding the BLDC ESC stage. Synchronises and glitch-filters the raw quadrature pins, decodes direction and x4 position, and measures the period between filtered A rising edges in clock cycles. The ESC consumes `period_out` as its measured speed and `direction` as its rotation sense; stall detection provides a deterministic period when the motor stops.

## Interface
- `DATA_WIDTH`, 16: width of the period counter and `period_out`.
- `FILTER_LEN`, 3: number of consecutive equal synchronised samples required before a filtered input changes; legal range 2..8.
- `POS_WIDTH`, 24: width of the signed position counter.

- `clk`  in  1: single clock.
- `reset`  in  1: synchronous reset, active-high.
- `encoder_a`  in  1: raw encoder A, asynchronous.
- `encoder_b`  in  1: raw encoder B, asynchronous.
- `clear_pos`  in  1: synchronous position clear.
- `period_out`  out  DATA_WIDTH: last measured A-rise-to-A-rise period in clocks; reset 0.
- `period_valid`  out  1: one-cycle pulse when `period_out` is updated by a complete measurement; reset 0.
- `stalled`  out  1: no A rise within 2^DATA_WIDTH−1 clocks; reset 0.
- `direction`  out  2: 2'b10 forward, 2'b01 reverse, 2'b00 unknown or stopped; reset 2'b00.
- `illegal_step`  out  1: one-cycle pulse on a two-bit jump of the filtered state; reset 0.
- `position`  out  POS_WIDTH signed: x4 count, present only with `ENC_POSITION_EN`; reset 0.

## Operation
- Input path: two-flop synchroniser per pin, then filter. The filtered bit takes the new value only when the last `FILTER_LEN` synchronised samples are all equal. Filtered bits reset to 0.
- Decoder: `cur = {a_f, b_f}`, `prev` registered.
  - Forward sequence: 00→01→11→10→00. A step in this sequence sets `direction` to 2'b10 and increments `position` by 1.
  - Reverse sequence: the inverse. A reverse step sets `direction` to 2'b01 and decrements `position` by 1.
  - `cur == prev`: `direction` and `position` hold.
  - Two-bit change (00↔11, 01↔10): pulse `illegal_step`; `direction` and `position` hold.
- Period FSM, with states ARM, MEASURE and STALL. `cnt` is DATA_WIDTH bits.
  - ARM (after reset): `cnt` idle at 0. On an A rise, set `cnt` to 1 and go to MEASURE. No valid pulse.
  - MEASURE: `cnt` increments each clock.
    - On an A rise: `period_out <= cnt`, pulse `period_valid`, set `cnt` to 1, clear `stalled`.
    - If `cnt` reaches all-ones with no rise: go to STALL, set `stalled` to 1, `period_out <= {DATA_WIDTH{1'b1}}`, `direction <= 2'b00`.
  - STALL: `cnt` holds. On an A rise, set `cnt` to 1 and go to MEASURE; `stalled` stays 1 until the next valid measurement.
- An A rise means filtered A goes 0→1, as seen by the decoder register.
- `position` wraps modulo 2^POS_WIDTH; there is no saturation.
- Simultaneous `clear_pos` and a step: clear wins and `position` becomes 0.
- A rise in the same cycle that `cnt` reaches all-ones: the rise wins; report all-ones as a valid period and do not enter STALL.
- Reset mid-operation: every register returns to its reset value on the next clock edge, and the FSM returns to ARM.

## Timing
- Pin edge to filtered edge: 2 (synchroniser) + `FILTER_LEN` clocks for a clean edge.
- Filtered edge to `direction`, `position`, `illegal_step` and `period_out`/`period_valid`: 1 clock. All outputs are registered.
- `period_out` is stable between `period_valid` pulses.
- Pulses shorter than `FILTER_LEN` synchronised samples are rejected entirely.

## Configuration
- `ENC_POSITION_EN`:
  - Defined: the `position` port, the counter and `clear_pos` handling are compiled in.
  - Undefined: the `position` port is absent, `clear_pos` is ignored, and no position registers are synthesised. Direction, `illegal_step` and period behaviour are identical in both builds.

## Structure
- Package `enc_pkg`:
  - Direction constants `DIR_STOP = 2'b00`, `DIR_REV = 2'b01`, `DIR_FWD = 2'b10`.
  - Period FSM state enum.
  - Forward and reverse transition lookup.
- Sub-module `enc_glitch_filter`: synchroniser plus `FILTER_LEN` agreement filter, instantiated once per pin.

## Test plan
- Forward quadrature at 100 clocks per A cycle, 25 clocks per phase → first A rise arms with no pulse; every later rise gives `period_valid` with `period_out` = 100, `direction` = 2'b10, and `position` +4 per cycle.
- Same waveform reversed → `direction` = 2'b01; `position` decrements 4 per cycle; `period_out` = 100.
- 2-clock glitch on A with `FILTER_LEN`=3 → no filtered change, no `period_valid`, `position` unchanged.
- A and B toggled in the same cycle, 00→11 → one `illegal_step` pulse; `direction` and `position` unchanged.
- Inputs frozen after a valid measurement with `DATA_WIDTH`=8 → 255 clocks later `stalled`=1, `period_out`=255, `direction`=2'b00. Resume at period 40 → `stalled` clears and `period_out`=40 on the second rise.
- `clear_pos` asserted in the same cycle as a forward step, with `position`=17 → `position`=0. Reset asserted mid-measurement → all outputs 0 next cycle and the FSM returns to ARM.

Source files
------------

// File: rtl/enc_pkg.sv
// rtl/enc_pkg.sv - shared encoder constants, period FSM states and quadrature step lookup
package enc_pkg;

  localparam logic [1:0] DIR_STOP = 2'b00;
  localparam logic [1:0] DIR_REV  = 2'b01;
  localparam logic [1:0] DIR_FWD  = 2'b10;

  typedef enum logic [1:0] {
    ST_ARM     = 2'b00,
    ST_MEASURE = 2'b01,
    ST_STALL   = 2'b10
  } period_state_e;

  // Forward order is 00 -> 01 -> 11 -> 10 -> 00; reverse is its inverse.
  function automatic logic [1:0] fwd_next(input logic [1:0] s);
    logic [1:0] n;
    case (s)
      2'b00:   n = 2'b01;
      2'b01:   n = 2'b11;
      2'b11:   n = 2'b10;
      default: n = 2'b00;
    endcase
    return n;
  endfunction

  function automatic logic [1:0] rev_next(input logic [1:0] s);
    logic [1:0] n;
    case (s)
      2'b00:   n = 2'b10;
      2'b10:   n = 2'b11;
      2'b11:   n = 2'b01;
      default: n = 2'b00;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/enc_glitch_filter.sv
// rtl/enc_glitch_filter.sv - two-flop synchroniser followed by a FILTER_LEN-sample agreement filter
module enc_glitch_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic filt_o
);

  logic [1:0]            sync_q;
  logic [FILTER_LEN-2:0] hist_q;
  logic [FILTER_LEN-1:0] window;
  logic                  filt_q;

  // Window includes the current synchronised sample so a clean edge costs 2 + FILTER_LEN clocks.
  assign window = {hist_q, sync_q[1]};
  assign filt_o = filt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      hist_q <= '0;
      filt_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
      hist_q <= window[FILTER_LEN-2:0];
      if (&window) begin
        filt_q <= 1'b1;
      end else if (~|window) begin
        filt_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/quadrature_speed_meter.sv
// rtl/quadrature_speed_meter.sv - quadrature decode, A-rise period measurement and stall detect; ENC_POSITION_EN adds the x4 position counter
module quadrature_speed_meter
  import enc_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FILTER_LEN = 3,
  parameter int POS_WIDTH  = 24
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         encoder_a,
  input  logic                         encoder_b,
  input  logic                         clear_pos,
  output logic [DATA_WIDTH-1:0]        period_out,
  output logic                         period_valid,
  output logic                         stalled,
  output logic [1:0]                   direction,
  output logic                         illegal_step
`ifdef ENC_POSITION_EN
  ,
  output logic signed [POS_WIDTH-1:0]  position
`endif
);

  localparam logic [DATA_WIDTH-1:0] CNT_ONE = DATA_WIDTH'(1);

  logic                  a_f, b_f;
  logic [1:0]            cur, prev_q;
  logic                  step_fwd, step_rev, illegal, a_rise;
  period_state_e         state_q, state_d;
  logic [DATA_WIDTH-1:0] cnt_q, cnt_d, period_q, period_d;
  logic                  valid_q, valid_d, stalled_q, stalled_d, illegal_q;
  logic [1:0]            dir_q, dir_d;

  enc_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clk(clk), .reset(reset), .raw_i(encoder_a), .filt_o(a_f)
  );
  enc_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clk(clk), .reset(reset), .raw_i(encoder_b), .filt_o(b_f)
  );

  assign cur      = {a_f, b_f};
  assign step_fwd = (cur == fwd_next(prev_q));
  assign step_rev = (cur == rev_next(prev_q));
  assign illegal  = ((cur ^ prev_q) == 2'b11);
  assign a_rise   = cur[1] & ~prev_q[1];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    stalled_d = stalled_q;
    dir_d     = dir_q;
    if (step_fwd) begin
      dir_d = DIR_FWD;
    end else if (step_rev) begin
      dir_d = DIR_REV;
    end
    case (state_q)
      ST_ARM: begin
        if (a_rise) begin
          cnt_d   = CNT_ONE;
          state_d = ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        // A rise on the all-ones count still counts as a valid period.
        if (a_rise) begin
          period_d  = cnt_q;
          valid_d   = 1'b1;
          cnt_d     = CNT_ONE;
          stalled_d = 1'b0;
        end else if (&cnt_q) begin
          state_d   = ST_STALL;
          stalled_d = 1'b1;
          period_d  = '1;
          dir_d     = DIR_STOP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_STALL: begin
        if (a_rise) begin
          cnt_d   = CNT_ONE;
          state_d = ST_MEASURE;
        end
      end
      default: begin
        state_d = ST_ARM;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_ARM;
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      stalled_q <= 1'b0;
      dir_q     <= DIR_STOP;
      illegal_q <= 1'b0;
      prev_q    <= 2'b00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      stalled_q <= stalled_d;
      dir_q     <= dir_d;
      illegal_q <= illegal;
      prev_q    <= cur;
    end
  end

  assign period_out   = period_q;
  assign period_valid = valid_q;
  assign stalled      = stalled_q;
  assign direction    = dir_q;
  assign illegal_step = illegal_q;

`ifdef ENC_POSITION_EN
  localparam logic [POS_WIDTH-1:0] POS_ONE = POS_WIDTH'(1);
  logic [POS_WIDTH-1:0] pos_q;

  // Clear beats a coincident step; the count wraps freely.
  always_ff @(posedge clk) begin
    if (reset || clear_pos) begin
      pos_q <= '0;
    end else if (step_fwd) begin
      pos_q <= pos_q + POS_ONE;
    end else if (step_rev) begin
      pos_q <= pos_q - POS_ONE;
    end
  end

  assign position = pos_q;
`else
  logic unused_cfg;
  assign unused_cfg = clear_pos | (POS_WIDTH == 0);
`endif

endmodule

// File: tb/tb_quadrature_speed_meter.sv
// tb/tb_quadrature_speed_meter.sv - directed self-checking bench for quadrature_speed_meter
module tb_quadrature_speed_meter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       encoder_a = 1'b0;
  logic       encoder_b = 1'b0;
  logic       clear_pos = 1'b0;
  logic [7:0] period_out;
  logic       period_valid;
  logic       stalled;
  logic [1:0] direction;
  logic       illegal_step;
`ifdef ENC_POSITION_EN
  logic signed [23:0] position;
`endif

  int total = 0;
  int bad = 0;

  int         cyc = 0;
  int         vcount = 0;
  int         icount = 0;
  int         vcyc = 0;
  int         stall_cyc = 0;
  logic [7:0] last_per = '0;
  logic       stalled_prev = 1'b0;

  quadrature_speed_meter #(.DATA_WIDTH(8), .FILTER_LEN(3), .POS_WIDTH(24)) dut (
    .clk(clk),
    .reset(reset),
    .encoder_a(encoder_a),
    .encoder_b(encoder_b),
    .clear_pos(clear_pos),
    .period_out(period_out),
    .period_valid(period_valid),
    .stalled(stalled),
    .direction(direction),
    .illegal_step(illegal_step)
`ifdef ENC_POSITION_EN
    ,
    .position(position)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (period_valid) begin
      vcount = vcount + 1;
      last_per = period_out;
      vcyc = cyc;
    end
    if (illegal_step) icount = icount + 1;
    if (stalled && !stalled_prev) stall_cyc = cyc;
    stalled_prev = stalled;
  end

  task automatic clocks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    encoder_a = 1'b0;
    encoder_b = 1'b0;
    clear_pos = 1'b0;
    clocks(3);
    reset = 1'b0;
    clocks(1);
  endtask

  task automatic fwd_cycle(input int ph);
    {encoder_a, encoder_b} = 2'b01; clocks(ph);
    {encoder_a, encoder_b} = 2'b11; clocks(ph);
    {encoder_a, encoder_b} = 2'b10; clocks(ph);
    {encoder_a, encoder_b} = 2'b00; clocks(ph);
  endtask

  task automatic rev_cycle(input int ph);
    {encoder_a, encoder_b} = 2'b10; clocks(ph);
    {encoder_a, encoder_b} = 2'b11; clocks(ph);
    {encoder_a, encoder_b} = 2'b01; clocks(ph);
    {encoder_a, encoder_b} = 2'b00; clocks(ph);
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (period_out !== 8'd0) begin bad++; $display("FAIL reset_period got=%0d exp=0", period_out); end
    total++; if (period_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", period_valid); end
    total++; if (stalled !== 1'b0) begin bad++; $display("FAIL reset_stalled got=%0b exp=0", stalled); end
    total++; if (direction !== 2'b00) begin bad++; $display("FAIL reset_dir got=%0b exp=00", direction); end
    total++; if (illegal_step !== 1'b0) begin bad++; $display("FAIL reset_illegal got=%0b exp=0", illegal_step); end
`ifdef ENC_POSITION_EN
    total++; if (position !== 24'sd0) begin bad++; $display("FAIL reset_pos got=%0d exp=0", position); end
`endif
  endtask

  task automatic test_forward();
    int v0, i0;
    do_reset();
    v0 = vcount; i0 = icount;
    fwd_cycle(25);
    total++; if (vcount - v0 !== 0) begin bad++; $display("FAIL fwd_arm_nopulse got=%0d exp=0", vcount - v0); end
    repeat (3) fwd_cycle(25);
    total++; if (vcount - v0 !== 3) begin bad++; $display("FAIL fwd_valid_count got=%0d exp=3", vcount - v0); end
    total++; if (last_per !== 8'd100) begin bad++; $display("FAIL fwd_period got=%0d exp=100", last_per); end
    total++; if (period_out !== 8'd100) begin bad++; $display("FAIL fwd_period_hold got=%0d exp=100", period_out); end
    total++; if (direction !== 2'b10) begin bad++; $display("FAIL fwd_dir got=%0b exp=10", direction); end
    total++; if (icount - i0 !== 0) begin bad++; $display("FAIL fwd_illegal got=%0d exp=0", icount - i0); end
`ifdef ENC_POSITION_EN
    total++; if (position !== 24'sd16) begin bad++; $display("FAIL fwd_pos got=%0d exp=16", position); end
`endif
  endtask

  task automatic test_reverse();
    int v0;
    do_reset();
    v0 = vcount;
    repeat (4) rev_cycle(25);
    total++; if (vcount - v0 !== 3) begin bad++; $display("FAIL rev_valid_count got=%0d exp=3", vcount - v0); end
    total++; if (last_per !== 8'd100) begin bad++; $display("FAIL rev_period got=%0d exp=100", last_per); end
    total++; if (direction !== 2'b01) begin bad++; $display("FAIL rev_dir got=%0b exp=01", direction); end
`ifdef ENC_POSITION_EN
    total++; if (position !== -24'sd16) begin bad++; $display("FAIL rev_pos got=%0d exp=-16", position); end
`endif
  endtask

  task automatic test_glitch();
    int v0, i0;
    do_reset();
    v0 = vcount; i0 = icount;
    encoder_a = 1'b1; clocks(2);
    encoder_a = 1'b0; clocks(20);
    total++; if (direction !== 2'b00) begin bad++; $display("FAIL glitch2_dir got=%0b exp=00", direction); end
    total++; if (vcount - v0 !== 0) begin bad++; $display("FAIL glitch2_valid got=%0d exp=0", vcount - v0); end
`ifdef ENC_POSITION_EN
    total++; if (position !== 24'sd0) begin bad++; $display("FAIL glitch2_pos got=%0d exp=0", position); end
`endif
    encoder_a = 1'b1; clocks(3);
    encoder_a = 1'b0; clocks(20);
    total++; if (direction !== 2'b10) begin bad++; $display("FAIL pulse3_dir got=%0b exp=10", direction); end
    total++; if (vcount - v0 !== 0) begin bad++; $display("FAIL pulse3_valid got=%0d exp=0", vcount - v0); end
    total++; if (icount - i0 !== 0) begin bad++; $display("FAIL pulse3_illegal got=%0d exp=0", icount - i0); end
  endtask

  task automatic test_illegal();
    int i0;
    do_reset();
    i0 = icount;
    {encoder_a, encoder_b} = 2'b11; clocks(15);
    total++; if (icount - i0 !== 1) begin bad++; $display("FAIL illegal_count got=%0d exp=1", icount - i0); end
    total++; if (direction !== 2'b00) begin bad++; $display("FAIL illegal_dir got=%0b exp=00", direction); end
`ifdef ENC_POSITION_EN
    total++; if (position !== 24'sd0) begin bad++; $display("FAIL illegal_pos got=%0d exp=0", position); end
`endif
  endtask

  task automatic test_stall();
    int v0;
    do_reset();
    repeat (2) fwd_cycle(25);
    total++; if (stalled !== 1'b0) begin bad++; $display("FAIL prestall_stalled got=%0b exp=0", stalled); end
    clocks(260);
    total++; if (stalled !== 1'b1) begin bad++; $display("FAIL stall_flag got=%0b exp=1", stalled); end
    total++; if (period_out !== 8'd255) begin bad++; $display("FAIL stall_period got=%0d exp=255", period_out); end
    total++; if (direction !== 2'b00) begin bad++; $display("FAIL stall_dir got=%0b exp=00", direction); end
    total++; if (stall_cyc - vcyc !== 255) begin bad++; $display("FAIL stall_latency got=%0d exp=255", stall_cyc - vcyc); end
    v0 = vcount;
    fwd_cycle(10);
    total++; if (stalled !== 1'b1) begin bad++; $display("FAIL resume1_stalled got=%0b exp=1", stalled); end
    total++; if (vcount - v0 !== 0) begin bad++; $display("FAIL resume1_valid got=%0d exp=0", vcount - v0); end
    total++; if (period_out !== 8'd255) begin bad++; $display("FAIL resume1_period got=%0d exp=255", period_out); end
    fwd_cycle(10);
    total++; if (stalled !== 1'b0) begin bad++; $display("FAIL resume2_stalled got=%0b exp=0", stalled); end
    total++; if (vcount - v0 !== 1) begin bad++; $display("FAIL resume2_valid got=%0d exp=1", vcount - v0); end
    total++; if (last_per !== 8'd40) begin bad++; $display("FAIL resume2_period got=%0d exp=40", last_per); end
    total++; if (direction !== 2'b10) begin bad++; $display("FAIL resume2_dir got=%0b exp=10", direction); end
  endtask

  task automatic test_overflow_edge();
    int v0;
    do_reset();
    v0 = vcount;
    encoder_a = 1'b1; clocks(100);
    encoder_a = 1'b0; clocks(155);
    encoder_a = 1'b1; clocks(10);
    total++; if (vcount - v0 !== 1) begin bad++; $display("FAIL ovf_valid got=%0d exp=1", vcount - v0); end
    total++; if (last_per !== 8'd255) begin bad++; $display("FAIL ovf_period got=%0d exp=255", last_per); end
    total++; if (stalled !== 1'b0) begin bad++; $display("FAIL ovf_stalled got=%0b exp=0", stalled); end
    total++; if (direction !== 2'b01) begin bad++; $display("FAIL ovf_dir got=%0b exp=01", direction); end
  endtask

  task automatic test_clear_pos();
`ifdef ENC_POSITION_EN
    do_reset();
    repeat (4) fwd_cycle(10);
    {encoder_a, encoder_b} = 2'b01; clocks(10);
    total++; if (position !== 24'sd17) begin bad++; $display("FAIL clr_pre_pos got=%0d exp=17", position); end
    {encoder_a, encoder_b} = 2'b11; clocks(5);
    clear_pos = 1'b1; clocks(1);
    clear_pos = 1'b0;
    total++; if (position !== 24'sd0) begin bad++; $display("FAIL clr_pos got=%0d exp=0", position); end
    clocks(10);
    total++; if (position !== 24'sd0) begin bad++; $display("FAIL clr_pos_hold got=%0d exp=0", position); end
    total++; if (direction !== 2'b10) begin bad++; $display("FAIL clr_dir got=%0b exp=10", direction); end
`endif
  endtask

  task automatic test_reset_mid();
    int v0;
    do_reset();
    repeat (2) fwd_cycle(25);
    clocks(10);
    reset = 1'b1; clocks(1);
    total++; if (period_out !== 8'd0) begin bad++; $display("FAIL midrst_period got=%0d exp=0", period_out); end
    total++; if (direction !== 2'b00) begin bad++; $display("FAIL midrst_dir got=%0b exp=00", direction); end
    total++; if (stalled !== 1'b0) begin bad++; $display("FAIL midrst_stalled got=%0b exp=0", stalled); end
    total++; if (period_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%0b exp=0", period_valid); end
    reset = 1'b0;
    v0 = vcount;
    fwd_cycle(25);
    total++; if (vcount - v0 !== 0) begin bad++; $display("FAIL midrst_arm got=%0d exp=0", vcount - v0); end
    fwd_cycle(25);
    total++; if (vcount - v0 !== 1) begin bad++; $display("FAIL midrst_meas got=%0d exp=1", vcount - v0); end
    total++; if (last_per !== 8'd100) begin bad++; $display("FAIL midrst_period2 got=%0d exp=100", last_per); end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_glitch();
    test_illegal();
    test_stall();
    test_overflow_edge();
    test_clear_pos();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
